// File: rtl/pic_control_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : pic_control_bus_seq
// Description : Clocked 8259 read/write control bus. It synchronises the CPU
//               strobes, address and data, and detects completed write cycles.
//               It sequences ICW1->ICW2->[ICW3]->[ICW4] initialisation, decodes
//               each committed write into a one-cycle ICW/OCW strobe, and tracks
//               the OCW3 read-register selection.
// Ports       : clk, reset (sync, active-low)
//               CS, rd_enable, wr_enable (active-low), A1, bi_data_bus  - CPU side
//               internal_bus           - last committed write data
//               write_ICW1..4, write_OCW1..3 - one-cycle decode strobes
//               read, read_select      - read level and register selection
//               init_done, single_mode, icw4_needed - init status
// Revision    : 1.0 - initial release
// ============================================================================
module pic_control_bus_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  rd_enable,
    input  logic                  wr_enable,
    input  logic                  A1,
    input  logic [DATA_WIDTH-1:0] bi_data_bus,
    output logic [DATA_WIDTH-1:0] internal_bus,
    output logic                  write_ICW1,
    output logic                  write_ICW2,
    output logic                  write_ICW3,
    output logic                  write_ICW4,
    output logic                  write_OCW1,
    output logic                  write_OCW2,
    output logic                  write_OCW3,
    output logic                  read,
    output logic [1:0]            read_select,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ICW2  = 3'd1;
    localparam logic [2:0] c_ST_ICW3  = 3'd2;
    localparam logic [2:0] c_ST_ICW4  = 3'd3;
    localparam logic [2:0] c_ST_READY = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronisers (stage 0 samples the pins)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_a1_sync;
    logic [DATA_WIDTH-1:0]  r_data_sync [SYNC_STAGES];
    // Bit k set once the chain has shifted k+1 real samples since reset;
    // the top bit qualifies the registered write-active flag.
    logic [SYNC_STAGES:0]   r_sync_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cs_sync    <= '1;
            r_rd_sync    <= '1;
            r_wr_sync    <= '1;
            r_a1_sync    <= '0;
            r_sync_valid <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
        end else begin
            r_cs_sync[0]   <= CS;
            r_rd_sync[0]   <= rd_enable;
            r_wr_sync[0]   <= wr_enable;
            r_a1_sync[0]   <= A1;
            r_data_sync[0] <= bi_data_bus;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_cs_sync[i]   <= r_cs_sync[i-1];
                r_rd_sync[i]   <= r_rd_sync[i-1];
                r_wr_sync[i]   <= r_wr_sync[i-1];
                r_a1_sync[i]   <= r_a1_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_sync_valid <= {r_sync_valid[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic                  w_cs_s;
    logic                  w_rd_s;
    logic                  w_wr_s;
    logic                  w_a1_s;
    logic [DATA_WIDTH-1:0] w_data_s;
    logic                  w_wr_act;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
    assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
    assign w_a1_s   = r_a1_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_wr_act = ~w_cs_s & ~w_wr_s;

    // ------------------------------------------------------------------
    // Write-cycle detection
    // ------------------------------------------------------------------
    logic                  r_wr_act_q;
    logic                  r_armed;
    logic                  r_hold_a1;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_commit;
    logic                  r_cmt_a1;
    logic [DATA_WIDTH-1:0] r_cmt_data;
    logic                  w_wr_rise;
    logic                  w_wr_fall;

    // A rising edge only counts once r_wr_act_q reflects a genuine sample.
    // A write already low when reset releases never shows a 0->1 edge,
    // so it is never armed and is dropped.
    assign w_wr_rise = w_wr_act & ~r_wr_act_q & r_sync_valid[SYNC_STAGES];
    assign w_wr_fall = r_armed & r_wr_act_q & ~w_wr_act;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_act_q  <= 1'b0;
            r_armed     <= 1'b0;
            r_hold_a1   <= 1'b0;
            r_hold_data <= '0;
            r_commit    <= 1'b0;
            r_cmt_a1    <= 1'b0;
            r_cmt_data  <= '0;
        end else begin
            r_wr_act_q <= w_wr_act;
            if (w_wr_fall) begin
                r_armed <= 1'b0;
            end else if (w_wr_rise) begin
                r_armed <= 1'b1;
            end
            // Address/data as seen on the last cycle the write was active.
            if (w_wr_act) begin
                r_hold_a1   <= w_a1_s;
                r_hold_data <= w_data_s;
            end
            // Snapshot at commit so a back-to-back write cannot disturb decode.
            r_commit <= w_wr_fall;
            if (w_wr_fall) begin
                r_cmt_a1   <= r_hold_a1;
                r_cmt_data <= r_hold_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Init sequencer and command decode
    // r_strobe: [0]ICW1 [1]ICW2 [2]ICW3 [3]ICW4 [4]OCW1 [5]OCW2 [6]OCW3
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [6:0]            r_strobe;
    logic [DATA_WIDTH-1:0] r_bus;
    logic [1:0]            r_rsel;
    logic                  r_single;
    logic                  r_ic4;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_strobe <= '0;
            r_bus    <= '0;
            r_rsel   <= 2'b00;
            r_single <= 1'b0;
            r_ic4    <= 1'b0;
        end else begin
            r_strobe <= '0;
            if (r_commit) begin
                r_bus <= r_cmt_data;
                if (!r_cmt_a1 && r_cmt_data[4]) begin
                    // ICW1 restarts initialisation from any state.
                    r_strobe[0] <= 1'b1;
                    r_single    <= r_cmt_data[1];
                    r_ic4       <= r_cmt_data[0];
                    r_rsel      <= 2'b00;
                    r_state     <= c_ST_ICW2;
                end else if (r_cmt_a1) begin
                    case (r_state)
                        c_ST_ICW2: begin
                            r_strobe[1] <= 1'b1;
                            if (!r_single)  r_state <= c_ST_ICW3;
                            else if (r_ic4) r_state <= c_ST_ICW4;
                            else            r_state <= c_ST_READY;
                        end
                        c_ST_ICW3: begin
                            r_strobe[2] <= 1'b1;
                            r_state     <= r_ic4 ? c_ST_ICW4 : c_ST_READY;
                        end
                        c_ST_ICW4: begin
                            r_strobe[3] <= 1'b1;
                            r_state     <= c_ST_READY;
                        end
                        c_ST_READY: r_strobe[4] <= 1'b1;
                        default: ;
                    endcase
                end else if (r_state == c_ST_READY) begin
                    if (!r_cmt_data[3]) begin
                        r_strobe[5] <= 1'b1;
                    end else begin
                        r_strobe[6] <= 1'b1;
                        // RR selects; RIS picks ISR over IRR.
                        if (r_cmt_data[1]) begin
                            r_rsel <= r_cmt_data[0] ? 2'b01 : 2'b00;
                        end
                    end
                end
            end
        end
    end

    assign internal_bus = r_bus;
    assign write_ICW1   = r_strobe[0];
    assign write_ICW2   = r_strobe[1];
    assign write_ICW3   = r_strobe[2];
    assign write_ICW4   = r_strobe[3];
    assign write_OCW1   = r_strobe[4];
    assign write_OCW2   = r_strobe[5];
    assign write_OCW3   = r_strobe[6];
    assign init_done    = (r_state == c_ST_READY);
    assign single_mode  = r_single;
    assign icw4_needed  = r_ic4;

    // A pending write masks the read; A1 during a read reports IMR without
    // touching the stored OCW3 selection.
    assign read        = ~w_cs_s & ~w_rd_s & ~w_wr_act;
    assign read_select = (read & w_a1_s) ? 2'b10 : r_rsel;

endmodule
`default_nettype wire

// File: tb/tb_pic_control_bus_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_control_bus_seq
// Description : Self-checking bench for pic_control_bus_seq. A transaction-level
//               model schedules each announced write's effect SYNC_STAGES+1
//               edges after release and a per-cycle compare checks all outputs;
//               directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_control_bus_seq;

    localparam int S     = 2;
    localparam int HSIZE = 4096;

    logic       clk;
    logic       reset;
    logic       CS;
    logic       rd_enable;
    logic       wr_enable;
    logic       A1;
    logic [7:0] bi_data_bus;
    logic [7:0] internal_bus;
    logic       write_ICW1, write_ICW2, write_ICW3, write_ICW4;
    logic       write_OCW1, write_OCW2, write_OCW3;
    logic       read;
    logic [1:0] read_select;
    logic       init_done, single_mode, icw4_needed;

    pic_control_bus_seq #(.DATA_WIDTH(8), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .CS(CS), .rd_enable(rd_enable),
        .wr_enable(wr_enable), .A1(A1), .bi_data_bus(bi_data_bus),
        .internal_bus(internal_bus),
        .write_ICW1(write_ICW1), .write_ICW2(write_ICW2),
        .write_ICW3(write_ICW3), .write_ICW4(write_ICW4),
        .write_OCW1(write_OCW1), .write_OCW2(write_OCW2),
        .write_OCW3(write_OCW3),
        .read(read), .read_select(read_select), .init_done(init_done),
        .single_mode(single_mode), .icw4_needed(icw4_needed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] strobes;
    assign strobes = {write_OCW3, write_OCW2, write_OCW1, write_ICW4,
                      write_ICW3, write_ICW2, write_ICW1};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int         due;
        bit         a1;
        logic [7:0] d;
    } wr_t;
    wr_t pq[$];

    // model states: 0 IDLE, 1 awaiting ICW2, 2 awaiting ICW3, 3 awaiting ICW4, 4 READY
    int         m_state;
    bit         m_single, m_ic4;
    logic [7:0] m_bus;
    logic [1:0] m_rsel;
    logic [6:0] m_strobe;
    int         cyc = 0;
    bit         h_cs [HSIZE];
    bit         h_rd [HSIZE];
    bit         h_wr [HSIZE];
    bit         h_a1 [HSIZE];

    always @(posedge clk) begin
        cyc++;
        if (cyc < HSIZE) begin
            h_cs[cyc] = reset ? CS : 1'b1;
            h_rd[cyc] = reset ? rd_enable : 1'b1;
            h_wr[cyc] = reset ? wr_enable : 1'b1;
            h_a1[cyc] = reset ? A1 : 1'b0;
        end
        if (!reset) begin
            m_state = 0; m_single = 0; m_ic4 = 0;
            m_bus = 8'h00; m_rsel = 2'b00; m_strobe = 7'h00;
            pq.delete();
        end else begin
            m_strobe = 7'h00;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                wr_t w;
                w = pq.pop_front();
                m_bus = w.d;
                if (!w.a1 && w.d[4]) begin
                    m_strobe[0] = 1; m_single = w.d[1]; m_ic4 = w.d[0];
                    m_rsel = 2'b00; m_state = 1;
                end else if (w.a1) begin
                    case (m_state)
                        1: begin m_strobe[1] = 1; m_state = !m_single ? 2 : (m_ic4 ? 3 : 4); end
                        2: begin m_strobe[2] = 1; m_state = m_ic4 ? 3 : 4; end
                        3: begin m_strobe[3] = 1; m_state = 4; end
                        4: m_strobe[4] = 1;
                        default: ;
                    endcase
                end else if (m_state == 4) begin
                    if (!w.d[3]) m_strobe[5] = 1;
                    else begin
                        m_strobe[6] = 1;
                        if (w.d[1]) m_rsel = w.d[0] ? 2'b01 : 2'b00;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < HSIZE) begin
            int  n;
            bit  cs_s, rd_s, wr_s, a1_s, e_read;
            logic [1:0] e_rsel;
            // Outputs after edge cyc reflect pins sampled S-1 edges earlier.
            n = cyc - S + 1;
            if (n >= 1) begin
                cs_s = h_cs[n]; rd_s = h_rd[n]; wr_s = h_wr[n]; a1_s = h_a1[n];
            end else begin
                cs_s = 1; rd_s = 1; wr_s = 1; a1_s = 0;
            end
            e_read = !cs_s && !rd_s && !(!cs_s && !wr_s);
            e_rsel = (e_read && a1_s) ? 2'b10 : m_rsel;
            chk("strobes", strobes, m_strobe);
            chk("internal_bus", internal_bus, m_bus);
            chk("init_done", init_done, (m_state == 4));
            chk("single_mode", single_mode, m_single);
            chk("icw4_needed", icw4_needed, m_ic4);
            chk("read", read, e_read);
            chk("read_select", read_select, e_rsel);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input bit a1, input logic [7:0] d, input bit rd_too, input int lat_idx);
        int rel;
        int off;
        bit found;
        @(negedge clk);
        A1 = a1; bi_data_bus = d; CS = 0; wr_enable = 0; rd_enable = rd_too ? 1'b0 : 1'b1;
        repeat (3) @(negedge clk);
        // Data changes with the release; the commit must use the held value.
        wr_enable = 1; CS = 1; rd_enable = 1; bi_data_bus = ~d;
        rel = cyc + 1;
        pq.push_back('{due: rel + S + 1, a1: a1, d: d});
        found = 0; off = 0;
        for (int k = 0; k < S + 6; k++) begin
            @(negedge clk);
            if (lat_idx >= 0 && !found && strobes[lat_idx]) begin
                found = 1; off = cyc - rel;
            end
        end
        if (lat_idx >= 0) begin
            chk("strobe_seen", found, 1);
            if (found) chk("strobe_latency", off, 3);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (S + 2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with a write already in progress; it must be dropped.
        reset = 0; CS = 0; wr_enable = 0; rd_enable = 1; A1 = 0; bi_data_bus = 8'h13;
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (4) @(negedge clk);
        wr_enable = 1;
        repeat (2) @(negedge clk);
        CS = 1;
        repeat (6) @(negedge clk);
        chk("rst_bus", internal_bus, 8'h00);
        chk("rst_init", init_done, 0);
        chk("rst_single", single_mode, 0);

        // ICW1 single+IC4, ICW2, ICW4
        do_write(0, 8'h13, 0, 0);
        do_write(1, 8'h20, 0, 1);
        do_write(1, 8'h01, 0, 3);
        chk("seq1_init", init_done, 1);
        chk("seq1_single", single_mode, 1);
        chk("seq1_ic4", icw4_needed, 1);
        chk("seq1_bus", internal_bus, 8'h01);

        // Cascade without ICW4
        do_write(0, 8'h10, 0, 0);
        do_write(1, 8'h08, 0, 1);
        chk("seq2_not_ready", init_done, 0);
        do_write(1, 8'h04, 0, 2);
        chk("seq2_init", init_done, 1);
        chk("seq2_ic4", icw4_needed, 0);
        chk("seq2_bus", internal_bus, 8'h04);

        // OCWs in READY
        do_write(1, 8'hFF, 0, 4);
        do_write(0, 8'h20, 0, 5);
        do_write(0, 8'h0B, 0, 6);
        chk("ocw3_rsel", read_select, 2'b01);

        // Read cycle
        @(negedge clk); CS = 0; rd_enable = 0; A1 = 0;
        repeat (S + 2) @(negedge clk);
        chk("rd_level", read, 1);
        chk("rd_sel_isr", read_select, 2'b01);
        A1 = 1;
        repeat (S + 1) @(negedge clk);
        chk("rd_sel_imr", read_select, 2'b10);
        CS = 1; rd_enable = 1; A1 = 0;
        repeat (S + 2) @(negedge clk);
        chk("rd_released", read, 0);
        chk("rsel_kept", read_select, 2'b01);

        // Simultaneous read and write strobes: write wins
        do_write(1, 8'h55, 1, 4);
        chk("simul_bus", internal_bus, 8'h55);

        // IDLE write ignored but bus updates
        pulse_reset();
        do_write(1, 8'hA5, 0, -1);
        chk("idle_bus", internal_bus, 8'hA5);
        chk("idle_init", init_done, 0);

        // Mid-init ICW1 restart
        do_write(0, 8'h12, 0, 0);
        do_write(1, 8'h40, 0, 1);
        do_write(0, 8'h0B, 0, 6);
        chk("mid_rsel_set", read_select, 2'b01);
        do_write(0, 8'h10, 0, 0);
        chk("mid_rsel_clr", read_select, 2'b00);
        do_write(1, 8'h08, 0, 1);
        do_write(0, 8'h12, 0, 0);
        do_write(0, 8'h0B, 0, -1);
        chk("mid_ignored_bus", internal_bus, 8'h0B);
        do_write(1, 8'h30, 0, 1);
        chk("mid_init", init_done, 1);
        chk("mid_single", single_mode, 1);
        chk("mid_ic4", icw4_needed, 0);
        chk("mid_bus", internal_bus, 8'h30);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pic_control_bus_seq.md
Name: pic_control_bus_seq

Overview:
Clocked, parametrised successor to the 8259 read/write control bus. It synchronises CS, rd_enable, wr_enable, A1 and the data bus from the CPU side, and detects complete write cycles. An ICW1→ICW2→[ICW3]→[ICW4] initialisation state machine sequences the writes, and each committed write is decoded into one-cycle ICW/OCW strobes. It also tracks the OCW3 read-register selection and drives the internal bus to the IRR, ISR and IMR blocks.

Parameters:
DATA_WIDTH, 8, bus width (≥8); decode uses bits [4:0], upper bits pass through to internal_bus
SYNC_STAGES, 2, synchroniser depth (1..3) applied identically to CS, rd_enable, wr_enable, A1, bi_data_bus

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous reset, active-low (reset=0 at a clk edge resets the block)
CS  input  1  chip select, active-low
rd_enable  input  1  read strobe, active-low
wr_enable  input  1  write strobe, active-low
A1  input  1  register address
bi_data_bus  input  DATA_WIDTH  CPU write data
internal_bus  output  DATA_WIDTH  last committed write data
write_ICW1, write_ICW2, write_ICW3, write_ICW4  output  1 each  one-cycle ICW strobes
write_OCW1, write_OCW2, write_OCW3  output  1 each  one-cycle OCW strobes
read  output  1  read cycle active (level)
read_select  output  2  00 IRR, 01 ISR, 10 IMR
init_done  output  1  state==READY
single_mode  output  1  ICW1 D1 (SNGL)
icw4_needed  output  1  ICW1 D0 (IC4)

Behaviour:
- Reset (reset=0 at an edge) clears:
  - all synchroniser flops to the inactive value (CS/strobes=1, data/A1=0)
  - all strobes, read, internal_bus=0, read_select=00, init_done=0, single_mode=0, icw4_needed=0
  - state=IDLE, armed=0
- wr_act = ~CS_s & ~wr_enable_s, where _s is the last synchroniser stage. armed sets when wr_act goes 0→1.
- Commit when armed & wr_act_q=1 & wr_act=0; armed then clears.
- Commit uses the A1_s and data_s held on the last cycle wr_act=1.
- A write already in progress when reset releases is discarded, because armed=0.
- Latency: from the first edge that samples CS or wr_enable high, the strobe asserts SYNC_STAGES+1 edges later and is high for exactly one cycle. internal_bus updates on that same edge and holds until the next commit.
- Decode at commit, in priority order:
  - A1=0 & D4=1: ICW1 in any state. Pulse write_ICW1, latch single_mode=D1 and icw4_needed=D0, read_select=00, state→ICW2, init_done=0.
  - State ICW2 & A1=1: pulse write_ICW2. Next state is ICW3 if !single_mode, else ICW4 if icw4_needed, else READY.
  - State ICW3 & A1=1: pulse write_ICW3. Next state is ICW4 if icw4_needed, else READY.
  - State ICW4 & A1=1: pulse write_ICW4, state→READY.
  - State READY & A1=1: pulse write_OCW1.
  - State READY & A1=0 & D4=0 & D3=0: pulse write_OCW2.
  - State READY & A1=0 & D4=0 & D3=1: pulse write_OCW3. If D1 (RR)=1, read_select = D0 (RIS) ? 01 : 00; if RR=0, read_select is unchanged.
  - Any other commit (IDLE non-ICW1, or init state with A1=0 & D4=0) is ignored: no strobe and no state change, but internal_bus still updates.
- At most one write_* strobe is high in any cycle.
- read = ~CS_s & ~rd_enable_s & ~wr_act, so a write has priority when both strobes are low. A1_s=1 during a read forces read_select to report 10 only while read is high; the stored OCW3 selection is unchanged.
- States are IDLE, ICW2, ICW3, ICW4, READY. READY persists until ICW1 or reset.

Test Plan:
- Reset held low 3 cycles with CS=0, wr_enable=0, then released with wr_enable released later → no strobe, state IDLE, all outputs 0.
- ICW1=0x13 (A1=0), ICW2=0x20, ICW4=0x01 (A1=1) → write_ICW1/ICW2/ICW4 each 1 cycle, no write_ICW3, single_mode=1, icw4_needed=1, init_done=1; each pulse SYNC_STAGES+1 edges after strobe release.
- ICW1=0x10, ICW2=0x08, ICW3=0x04 → write_ICW3 pulses, init_done=1 after ICW3, icw4_needed=0, internal_bus=0x04.
- READY: A1=1 0xFF → write_OCW1; A1=0 0x20 → write_OCW2; A1=0 0x0B → write_OCW3 and read_select=01; then CS=0, rd_enable=0, A1=0 → read=1, read_select=01; with A1=1 → read_select=10.
- CS=0 with wr_enable=0 and rd_enable=0 together → read=0, one write strobe on release. A1=1 write in IDLE → no strobe, internal_bus updated.
- Mid-init ICW1=0x12 after ICW2 → state ICW2 again, read_select=00, next A1=1 write gives write_ICW2 (not ICW3/OCW1).
